// File: rtl/pu_cmp_if.sv
`default_nettype none
// ============================================================================
//  Module   : pu_cmp_if
//  Purpose  : Shared PU bus bundle (strobes, operation select, data/attr).
//  Revision : 1.0  initial release
// ============================================================================
interface pu_cmp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int SEL_WIDTH  = 4
);
    logic                  signal_wr;
    logic                  signal_oe;
    logic [SEL_WIDTH-1:0]  signal_sel;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ATTR_WIDTH-1:0] attr_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [ATTR_WIDTH-1:0] attr_out;

    modport master (
        output signal_wr, signal_oe, signal_sel, data_in, attr_in,
        input  data_out, attr_out
    );

    modport slave (
        input  signal_wr, signal_oe, signal_sel, data_in, attr_in,
        output data_out, attr_out
    );
endinterface
`default_nettype wire

// File: rtl/pu_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : pu_cmp
//  Purpose  : Two-operand comparator PU; yields a 1-bit boolean on data_out[0].
//             Define PU_CMP_SIGNED_EN for signed LT/LE/GT/GE (default unsigned).
//  Revision : 1.0  initial release
// ============================================================================
module pu_cmp #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int SEL_WIDTH  = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    pu_cmp_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HAVE_A = 2'd1,
        ST_EVAL   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [2:0] OP_EQ = 3'd0;
    localparam logic [2:0] OP_NE = 3'd1;
    localparam logic [2:0] OP_LT = 3'd2;
    localparam logic [2:0] OP_LE = 3'd3;
    localparam logic [2:0] OP_GT = 3'd4;
    localparam logic [2:0] OP_GE = 3'd5;

    localparam logic [ATTR_WIDTH-1:0] ATTR_INVALID = {{(ATTR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] arg_a_q, arg_a_d;
    logic [DATA_WIDTH-1:0] arg_b_q, arg_b_d;
    logic [ATTR_WIDTH-1:0] attr_a_q, attr_a_d;
    logic [ATTR_WIDTH-1:0] attr_b_q, attr_b_d;
    logic [2:0]            op_q, op_d;
    logic                  result_q, result_d;
    logic [ATTR_WIDTH-1:0] result_attr_q, result_attr_d;

    logic cmp_eq;
    logic cmp_lt;
    logic cmp_res;
    logic cmp_illegal;
    logic unused_bits;

    // Only the INVALID flag of each operand and the low 3 select bits matter.
    assign unused_bits = ^{attr_a_q[ATTR_WIDTH-1:1], attr_b_q[ATTR_WIDTH-1:1],
                           bus.signal_sel[SEL_WIDTH-1:3]};

    assign cmp_eq = (arg_a_q == arg_b_q);
`ifdef PU_CMP_SIGNED_EN
    assign cmp_lt = ($signed(arg_a_q) < $signed(arg_b_q));
`else
    assign cmp_lt = (arg_a_q < arg_b_q);
`endif

    always_comb begin
        cmp_res     = 1'b0;
        cmp_illegal = 1'b0;
        case (op_q)
            OP_EQ:   cmp_res = cmp_eq;
            OP_NE:   cmp_res = ~cmp_eq;
            OP_LT:   cmp_res = cmp_lt;
            OP_LE:   cmp_res = cmp_lt | cmp_eq;
            OP_GT:   cmp_res = ~(cmp_lt | cmp_eq);
            OP_GE:   cmp_res = ~cmp_lt;
            default: cmp_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        arg_a_d       = arg_a_q;
        arg_b_d       = arg_b_q;
        attr_a_d      = attr_a_q;
        attr_b_d      = attr_b_q;
        op_d          = op_q;
        result_d      = result_q;
        result_attr_d = result_attr_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.signal_wr) begin
                    arg_a_d  = bus.data_in;
                    attr_a_d = bus.attr_in;
                    state_d  = ST_HAVE_A;
                end
            end
            ST_HAVE_A: begin
                if (bus.signal_wr) begin
                    arg_b_d  = bus.data_in;
                    attr_b_d = bus.attr_in;
                    op_d     = bus.signal_sel[2:0];
                    state_d  = ST_EVAL;
                end
            end
            default: begin
                // EVAL lasts one cycle; a write arriving here is dropped.
                result_d      = cmp_res;
                result_attr_d = {{(ATTR_WIDTH-1){1'b0}},
                                 attr_a_q[0] | attr_b_q[0] | cmp_illegal};
                state_d       = ST_DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            arg_a_q       <= '0;
            arg_b_q       <= '0;
            attr_a_q      <= '0;
            attr_b_q      <= '0;
            op_q          <= '0;
            result_q      <= 1'b0;
            result_attr_q <= '0;
        end else begin
            state_q       <= state_d;
            arg_a_q       <= arg_a_d;
            arg_b_q       <= arg_b_d;
            attr_a_q      <= attr_a_d;
            attr_b_q      <= attr_b_d;
            op_q          <= op_d;
            result_q      <= result_d;
            result_attr_q <= result_attr_d;
        end
    end

    // Read path is purely combinational so a read and a write can share a cycle.
    always_comb begin
        bus.data_out = '0;
        bus.attr_out = '0;
        if (bus.signal_oe) begin
            if (state_q == ST_DONE) begin
                bus.data_out = {{(DATA_WIDTH-1){1'b0}}, result_q};
                bus.attr_out = result_attr_q;
            end else begin
                bus.attr_out = ATTR_INVALID;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pu_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pu_cmp
//  Purpose  : Scoreboard bench for pu_cmp: directed cases plus random operations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pu_cmp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SW = 4;
`ifdef PU_CMP_SIGNED_EN
    localparam bit SIGNED_MODE = 1'b1;
`else
    localparam bit SIGNED_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pu_cmp_if #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .SEL_WIDTH(SW)) bus ();

    pu_cmp #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .SEL_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] attr;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference view of the unit: what a read would return now, and what is pending.
    bit            m_have_a;
    bit            m_eval_pending;
    bit            m_done;
    logic [DW-1:0] m_a;
    logic [AW-1:0] m_attr_a;
    bit            m_pend_res, m_pend_inv;
    bit            m_res, m_inv;

    // Returns {invalid, result} for A op B.
    function automatic logic [1:0] ref_cmp(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [2:0] op);
        longint sa, sb;
        if (SIGNED_MODE) begin
            sa = (a >= 32'h8000_0000) ? longint'(a) - 64'sd4294967296 : longint'(a);
            sb = (b >= 32'h8000_0000) ? longint'(b) - 64'sd4294967296 : longint'(b);
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        case (op)
            3'd0:    return {1'b0, a == b};
            3'd1:    return {1'b0, a != b};
            3'd2:    return {1'b0, sa <  sb};
            3'd3:    return {1'b0, sa <= sb};
            3'd4:    return {1'b0, sa >  sb};
            3'd5:    return {1'b0, sa >= sb};
            default: return 2'b10;
        endcase
    endfunction

    task automatic model_reset();
        m_have_a = 0; m_eval_pending = 0; m_done = 0;
        m_a = '0; m_attr_a = '0;
        m_pend_res = 0; m_pend_inv = 0; m_res = 0; m_inv = 0;
    endtask

    // One bus cycle: drive inputs, queue what the outputs must show, advance the model.
    task automatic step(input bit wr, input bit oe, input logic [DW-1:0] d,
                        input logic [AW-1:0] a, input logic [SW-1:0] s, input string tag);
        exp_t e;
        logic [1:0] r;
        @(posedge clk);
        #1;
        bus.signal_wr  = wr;
        bus.signal_oe  = oe;
        bus.data_in    = d;
        bus.attr_in    = a;
        bus.signal_sel = s;
        e.tag  = tag;
        e.data = '0;
        e.attr = '0;
        if (oe) begin
            if (m_done) begin
                e.data = DW'(m_res);
                e.attr = AW'(m_inv);
            end else begin
                e.attr = 4'b0001;
            end
        end
        exp_q.push_back(e);
        if (m_eval_pending) begin
            m_eval_pending = 0;
            m_done = 1;
            m_res  = m_pend_res;
            m_inv  = m_pend_inv;
        end else if (wr) begin
            if (!m_have_a) begin
                m_have_a = 1; m_done = 0; m_a = d; m_attr_a = a;
            end else begin
                r = ref_cmp(m_a, d, s[2:0]);
                m_pend_res = r[0];
                m_pend_inv = r[1] | m_attr_a[0] | a[0];
                m_have_a = 0;
                m_eval_pending = 1;
            end
        end
    endtask

    task automatic idle_bus();
        @(posedge clk);
        #1;
        bus.signal_wr = 0; bus.signal_oe = 0;
        bus.data_in = '0; bus.attr_in = '0; bus.signal_sel = '0;
    endtask

    // Full operation: A, B, a read during EVAL (must be INVALID), then the DONE read.
    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [SW-1:0] s,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ab, input string tag);
        step(1, 0, a, aa, '0, {tag, "_wa"});
        step(1, 0, b, ab, s,  {tag, "_wb"});
        step(0, 1, '0, '0, '0, {tag, "_eval"});
        step(0, 1, '0, '0, '0, tag);
    endtask

    task automatic apply_reset();
        idle_bus();
        #2;
        rst = 0;
        model_reset();
        @(negedge clk);
        #1;
        rst = 1;
    endtask

    // Monitor: every driven cycle has exactly one expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp = n_cmp + 1;
            if (bus.data_out !== e.data || bus.attr_out !== e.attr) begin
                n_err = n_err + 1;
                $display("FAIL %s: got data=%h attr=%b, want data=%h attr=%b",
                         e.tag, bus.data_out, bus.attr_out, e.data, e.attr);
            end
        end
    end

    initial begin
        logic [DW-1:0] ra, rb;
        logic [AW-1:0] raa, rab;
        logic [SW-1:0] rs;
        bus.signal_wr = 0; bus.signal_oe = 0;
        bus.data_in = '0; bus.attr_in = '0; bus.signal_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1;

        step(0, 1, '0, '0, '0, "reset_read");
        step(0, 0, '0, '0, '0, "reset_quiet");
        step(1, 0, 32'd99, '0, '0, "pre_reset_a");
        apply_reset();
        do_op(32'd5, 32'd5, 4'd0, '0, '0, "after_reset_eq");

        do_op(32'd7, 32'd7, 4'd0, '0, '0, "eq_7_7");
        step(0, 1, '0, '0, '0, "eq_reread");
        do_op(32'd7, 32'd7, 4'd1, '0, '0, "ne_7_7");
        do_op(32'd3, 32'd10, 4'd2, '0, '0, "lt_3_10");
        do_op(32'd3, 32'd10, 4'd5, '0, '0, "ge_3_10");
        do_op(32'hFFFF_FFFF, 32'd1, 4'd2, '0, '0, "lt_neg1_1");
        do_op(32'd5, 32'd2, 4'd4, 4'b0001, '0, "gt_attr_inv");
        do_op(32'd1, 32'd1, 4'd6, '0, '0, "illegal_op6");
        do_op(32'd1, 32'd1, 4'd15, '0, '0, "illegal_op7_hisel");

        do_op(32'd7, 32'd7, 4'd0, '0, '0, "pre_concurrent");
        step(1, 1, 32'd4, '0, '0, "concurrent_rd");
        step(1, 1, 32'd9, '0, 4'd3, "have_a_rd");
        step(0, 1, '0, '0, '0, "le_eval_rd");
        step(0, 1, '0, '0, '0, "le_4_9");

        // Back-to-back EQ pairs; the DONE cycle reads and writes the next A at once.
        ra = (($urandom & 1) != 0) ? 32'd42 : $urandom;
        step(1, 0, ra, '0, '0, "b2b_wa");
        for (int i = 0; i < 10; i++) begin
            rb = (($urandom & 1) != 0) ? ra : $urandom;
            step(1, 0, rb, '0, 4'd0, "b2b_wb");
            step(0, 0, '0, '0, '0, "b2b_eval");
            ra = (($urandom & 1) != 0) ? rb : $urandom;
            step(i < 9, 1, ra, '0, '0, "b2b_done");
        end

        for (int i = 0; i < 40; i++) begin
            ra  = (($urandom & 3) == 0) ? 32'(($urandom & 7) | 32'hFFFF_FFF8) : $urandom_range(0, 15);
            rb  = (($urandom & 3) == 0) ? ra : (($urandom & 1) != 0 ? $urandom : 32'($urandom_range(0, 15)));
            rs  = SW'($urandom);
            raa = (($urandom & 7) == 0) ? AW'($urandom) : AW'($urandom & 14);
            rab = (($urandom & 7) == 0) ? AW'($urandom) : AW'($urandom & 14);
            do_op(ra, rb, rs, raa, rab, "rand_op");
        end

        apply_reset();
        step(0, 1, '0, '0, '0, "final_reset_read");
        idle_bus();
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
